// File: rtl/nco_phase_accumulator_pkg.sv
// Shared constants and types for the NCO phase accumulator and its optional dither LFSR.
package nco_phase_accumulator_pkg;

    localparam int unsigned DEF_PHASE_WIDTH = 24;
    localparam int unsigned DEF_LUT_DEPTH   = 8;
    localparam int unsigned DEF_DIV_WIDTH   = 8;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 16'hB400;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

    typedef logic [DEF_PHASE_WIDTH-1:0] phase_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] state);
        lfsr_next = (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/nco_dither_lfsr.sv
// 16-bit Galois LFSR stepping once per sample tick; low bits feed the address dither.
module nco_dither_lfsr
    import nco_phase_accumulator_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_advance,
    output logic [OUT_WIDTH-1:0] o_dither
);

    logic [LFSR_WIDTH-1:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= LFSR_SEED;
        end else if (i_advance) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_dither = r_state[OUT_WIDTH-1:0];

endmodule

// File: rtl/nco_phase_accumulator.sv
// NCO phase stage: divided-rate FTW accumulation driving a sine LUT address.
// Optional address dither is built when NCO_DITHER_EN is defined.
module nco_phase_accumulator
    import nco_phase_accumulator_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int unsigned LUT_DEPTH   = DEF_LUT_DEPTH,
    parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [DIV_WIDTH-1:0]   i_div_rate,
    input  logic [PHASE_WIDTH-1:0] i_ftw_in,
    input  logic                   i_ftw_valid,
    output logic                   o_ftw_ready,
    input  logic [LUT_DEPTH-1:0]   i_phase_offset,
    output logic [LUT_DEPTH-1:0]   o_address,
    output logic                   o_addr_valid,
    output logic                   o_wrap
);

    logic [PHASE_WIDTH-1:0] r_phase;
    logic [PHASE_WIDTH-1:0] r_ftw_active;
    logic [PHASE_WIDTH-1:0] r_ftw_pending;
    logic                   r_pend_flag;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [LUT_DEPTH-1:0]   r_address;
    logic                   r_addr_valid;
    logic                   r_wrap;

    logic                   w_tick;
    logic                   w_xfer;
    logic                   w_carry;
    logic [PHASE_WIDTH-1:0] w_phase_next;
    logic [LUT_DEPTH-1:0]   w_addr_top;
    logic [LUT_DEPTH-1:0]   w_address;

    assign w_tick = i_enable && (r_div_cnt == i_div_rate);
    assign w_xfer = i_ftw_valid && !r_pend_flag;

    assign {w_carry, w_phase_next} = {1'b0, r_phase} + {1'b0, r_ftw_active};

`ifdef NCO_DITHER_EN
    localparam int unsigned FRAC_WIDTH = PHASE_WIDTH - LUT_DEPTH;

    logic [FRAC_WIDTH-1:0]  w_dither;
    logic [PHASE_WIDTH-1:0] w_dithered;

    nco_dither_lfsr #(
        .OUT_WIDTH(FRAC_WIDTH)
    ) u_dither (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_advance(w_tick),
        .o_dither (w_dither)
    );

    // Dither only shapes the address; the accumulator stays exact.
    assign w_dithered = w_phase_next + PHASE_WIDTH'(w_dither);
    assign w_addr_top = w_dithered[PHASE_WIDTH-1 -: LUT_DEPTH];
`else
    assign w_addr_top = w_phase_next[PHASE_WIDTH-1 -: LUT_DEPTH];
`endif

    assign w_address = w_addr_top + i_phase_offset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase       <= '0;
            r_ftw_active  <= '0;
            r_ftw_pending <= '0;
            r_pend_flag   <= 1'b0;
            r_div_cnt     <= '0;
            r_address     <= '0;
            r_addr_valid  <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_addr_valid <= w_tick;
            if (w_tick) begin
                r_phase   <= w_phase_next;
                r_address <= w_address;
                r_wrap    <= w_carry;
                r_div_cnt <= '0;
                // The tick's own addition above still used the old step.
                if (r_pend_flag) begin
                    r_ftw_active <= r_ftw_pending;
                    r_pend_flag  <= 1'b0;
                end
            end else if (i_enable) begin
                r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
            end
            if (w_xfer) begin
                r_ftw_pending <= i_ftw_in;
                r_pend_flag   <= 1'b1;
            end
        end
    end

    assign o_ftw_ready  = !r_pend_flag;
    assign o_address    = r_address;
    assign o_addr_valid = r_addr_valid;
    assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Self-checking bench for nco_phase_accumulator: directed scenarios plus a randomized
// run against an arithmetic reference model (dither modelled when NCO_DITHER_EN is set).
module tb_nco_phase_accumulator;

    localparam int unsigned PW = 24;
    localparam int unsigned LD = 8;
    localparam int unsigned DW = 8;
    localparam longint unsigned PHASE_MOD = 64'd1 << PW;
    localparam longint unsigned FRAC_MOD  = 64'd1 << (PW - LD);
    localparam longint unsigned ADDR_MOD  = 64'd1 << LD;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [DW-1:0] i_div_rate;
    logic [PW-1:0] i_ftw_in;
    logic          i_ftw_valid;
    logic          o_ftw_ready;
    logic [LD-1:0] i_phase_offset;
    logic [LD-1:0] o_address;
    logic          o_addr_valid;
    logic          o_wrap;

    int errors = 0;
    int checks = 0;
    int e_addr = 0;

    // Reference model state
    longint unsigned m_phase, m_active, m_pending, m_addr, m_lfsr;
    int unsigned     m_div;
    bit              m_pend, m_valid, m_wrap;

    nco_phase_accumulator dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_div_rate    (i_div_rate),
        .i_ftw_in      (i_ftw_in),
        .i_ftw_valid   (i_ftw_valid),
        .o_ftw_ready   (o_ftw_ready),
        .i_phase_offset(i_phase_offset),
        .o_address     (o_address),
        .o_addr_valid  (o_addr_valid),
        .o_wrap        (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit tick, xfer;
        longint unsigned sum, ap;
        if (i_reset) begin
            m_phase = 0; m_active = 0; m_pending = 0; m_addr = 0; m_lfsr = 64'hACE1;
            m_div = 0; m_pend = 0; m_valid = 0; m_wrap = 0;
        end else begin
            tick = i_enable && (m_div == int'(i_div_rate));
            xfer = i_ftw_valid && !m_pend;
            m_valid = tick;
            if (tick) begin
                sum = m_phase + m_active;
                m_wrap = (sum >= PHASE_MOD);
                m_phase = sum % PHASE_MOD;
                ap = m_phase;
`ifdef NCO_DITHER_EN
                ap = (ap + (m_lfsr % FRAC_MOD)) % PHASE_MOD;
                m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 64'hB400) : (m_lfsr / 2);
`endif
                m_addr = (ap / FRAC_MOD + longint'(i_phase_offset)) % ADDR_MOD;
                if (m_pend) begin
                    m_active = m_pending;
                    m_pend = 0;
                end
                m_div = 0;
            end else if (i_enable) begin
                m_div = (m_div + 1) % 256;
            end
            if (xfer) begin
                m_pending = longint'(i_ftw_in);
                m_pend = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_enable = 1'b1; i_ftw_valid = 1'b1; i_ftw_in = PW'($urandom);
        repeat (3) begin
            cyc();
            checks++; if (o_address !== '0) begin errors++; $display("FAIL reset addr: got %0d want 0", o_address); end
            checks++; if (o_addr_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", o_addr_valid); end
            checks++; if (o_wrap !== 1'b0) begin errors++; $display("FAIL reset wrap: got %b want 0", o_wrap); end
            checks++; if (o_ftw_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", o_ftw_ready); end
        end
        i_reset = 1'b0; i_ftw_valid = 1'b0; i_div_rate = '0;
        // Any retained FTW would make the address move.
        repeat (3) begin
            cyc();
            checks++; if (o_address !== '0) begin errors++; $display("FAIL reset retained addr: got %0d want 0", o_address); end
            checks++; if (o_ftw_ready !== 1'b1) begin errors++; $display("FAIL reset retained ready: got %b want 1", o_ftw_ready); end
        end
        i_enable = 1'b0;
    endtask

    task automatic test_free_run();
        i_ftw_in = 24'h010000; i_ftw_valid = 1'b1;
        cyc();
        i_ftw_valid = 1'b0;
        checks++; if (o_ftw_ready !== 1'b0) begin errors++; $display("FAIL free_run ready low: got %b want 0", o_ftw_ready); end
        i_div_rate = '0; i_enable = 1'b1;
        cyc();
        checks++; if (o_address !== '0 || o_addr_valid !== 1'b1) begin errors++; $display("FAIL free_run first: got addr %0d valid %b want 0/1", o_address, o_addr_valid); end
        checks++; if (o_ftw_ready !== 1'b1) begin errors++; $display("FAIL free_run ready high: got %b want 1", o_ftw_ready); end
        for (int i = 1; i <= 256; i++) begin
            cyc();
            checks++; if (o_address !== LD'(i % 256)) begin errors++; $display("FAIL free_run addr: got %0d want %0d", o_address, i % 256); end
            checks++; if (o_addr_valid !== 1'b1) begin errors++; $display("FAIL free_run valid: got %b want 1", o_addr_valid); end
            checks++; if (o_wrap !== (i == 256)) begin errors++; $display("FAIL free_run wrap at %0d: got %b want %b", i, o_wrap, i == 256); end
        end
        e_addr = 0;
    endtask

    task automatic test_divider();
        i_div_rate = 8'd3;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            if (i % 4 == 0) e_addr = (e_addr + 1) % 256;
            checks++; if (o_addr_valid !== (i % 4 == 0)) begin errors++; $display("FAIL divider valid cyc %0d: got %b want %b", i, o_addr_valid, i % 4 == 0); end
            checks++; if (o_address !== LD'(e_addr)) begin errors++; $display("FAIL divider addr: got %0d want %0d", o_address, e_addr); end
        end
        i_enable = 1'b0;
        repeat (5) begin
            cyc();
            checks++; if (o_addr_valid !== 1'b0) begin errors++; $display("FAIL hold valid: got %b want 0", o_addr_valid); end
            checks++; if (o_address !== LD'(e_addr)) begin errors++; $display("FAIL hold addr: got %0d want %0d", o_address, e_addr); end
        end
        // Counter resumes at 2: one more non-tick cycle, then the tick.
        i_enable = 1'b1;
        cyc();
        checks++; if (o_addr_valid !== 1'b0) begin errors++; $display("FAIL resume early valid: got %b want 0", o_addr_valid); end
        cyc();
        e_addr = (e_addr + 1) % 256;
        checks++; if (o_addr_valid !== 1'b1 || o_address !== LD'(e_addr)) begin errors++; $display("FAIL resume tick: got valid %b addr %0d want 1/%0d", o_addr_valid, o_address, e_addr); end
    endtask

    task automatic test_handshake();
        i_ftw_in = 24'h020000; i_ftw_valid = 1'b1;
        cyc();
        checks++; if (o_ftw_ready !== 1'b0) begin errors++; $display("FAIL hs ready after xfer: got %b want 0", o_ftw_ready); end
        i_ftw_in = 24'h030000;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (o_ftw_ready !== 1'b0) begin errors++; $display("FAIL hs ready pending: got %b want 0", o_ftw_ready); end
        end
        cyc();
        i_ftw_valid = 1'b0;
        e_addr = (e_addr + 1) % 256;
        checks++; if (o_ftw_ready !== 1'b1) begin errors++; $display("FAIL hs ready after tick: got %b want 1", o_ftw_ready); end
        checks++; if (o_address !== LD'(e_addr) || o_addr_valid !== 1'b1) begin errors++; $display("FAIL hs old step: got %0d want %0d", o_address, e_addr); end
        for (int k = 0; k < 2; k++) begin
            repeat (4) cyc();
            e_addr = (e_addr + 2) % 256;
            checks++; if (o_address !== LD'(e_addr) || o_addr_valid !== 1'b1) begin errors++; $display("FAIL hs new step %0d: got %0d want %0d", k, o_address, e_addr); end
        end
        checks++; if (o_ftw_ready !== 1'b1) begin errors++; $display("FAIL hs second offer taken: ready %b want 1", o_ftw_ready); end
    endtask

    task automatic test_offset();
        i_reset = 1'b1; i_enable = 1'b0;
        cyc();
        i_reset = 1'b0; i_phase_offset = 8'd64; i_ftw_in = 24'h010000; i_ftw_valid = 1'b1;
        cyc();
        i_ftw_valid = 1'b0; i_div_rate = '0; i_enable = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cyc();
            checks++; if (o_address !== LD'((k + 64) % 256)) begin errors++; $display("FAIL offset addr %0d: got %0d want %0d", k, o_address, (k + 64) % 256); end
        end
        i_phase_offset = '0;
    endtask

    task automatic test_random();
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            i_reset  = ($urandom_range(0, 599) == 0);
            i_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) i_div_rate = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) i_phase_offset = LD'($urandom);
            i_ftw_valid = ($urandom_range(0, 5) == 0);
            i_ftw_in = ($urandom_range(0, 1) == 0) ? 24'h008000 : PW'($urandom);
            cyc();
            checks++; if (o_addr_valid !== m_valid) begin errors++; $display("FAIL rand valid n=%0d: got %b want %b", n, o_addr_valid, m_valid); end
            checks++; if (o_address !== LD'(m_addr)) begin errors++; $display("FAIL rand addr n=%0d: got %0d want %0d", n, o_address, m_addr); end
            checks++; if (o_ftw_ready !== !m_pend) begin errors++; $display("FAIL rand ready n=%0d: got %b want %b", n, o_ftw_ready, !m_pend); end
            if (m_valid) begin
                checks++; if (o_wrap !== m_wrap) begin errors++; $display("FAIL rand wrap n=%0d: got %b want %b", n, o_wrap, m_wrap); end
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_div_rate = '0; i_ftw_in = '0;
        i_ftw_valid = 1'b0; i_phase_offset = '0;
        test_reset();
        test_free_run();
        test_divider();
        test_handshake();
        test_offset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_accumulator.md
# nco_phase_accumulator

Numerically controlled oscillator phase stage that drives the address input of the sine lookup table. It accumulates a frequency tuning word (FTW) at a programmable sample rate and emits a LUT_DEPTH-bit table address with a valid strobe and a wrap flag. The FTW is loaded through a ready/valid handshake and applied only on a sample tick, so frequency changes are phase-continuous.

## Interface
- PHASE_WIDTH, 24, accumulator width; PHASE_WIDTH-LUT_DEPTH must be in 1..16
- LUT_DEPTH, 8, address width; matches the sine table address width
- DIV_WIDTH, 8, sample-rate divider width
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high
- enable  input  1  run/hold
- div_rate  input  DIV_WIDTH  one tick every div_rate+1 enabled cycles
- ftw_in  input  PHASE_WIDTH  new tuning word
- ftw_valid  input  1  ftw_in offered
- ftw_ready  output  1  pending slot free
- phase_offset  input  LUT_DEPTH  constant added to the output address (e.g. 64 selects cosine)
- address  output  LUT_DEPTH  registered LUT address
- addr_valid  output  1  one-cycle strobe per new address
- wrap  output  1  phase accumulator overflowed on this update; qualified by addr_valid

## Operation
- Registers: phase, ftw_active, ftw_pending, pend_flag, div_cnt, address, addr_valid, wrap.
- Tick: enable && div_cnt==div_rate. On a tick div_cnt returns to 0; on other enabled cycles div_cnt increments. When enable is low, div_cnt and phase hold, no ticks occur, and addr_valid is 0.
- Tick update:
  - {carry, phase_next} = phase + ftw_active, modulo 2^PHASE_WIDTH.
  - address <= phase_next[PHASE_WIDTH-1 -: LUT_DEPTH] + phase_offset, modulo 2^LUT_DEPTH.
  - wrap <= carry.
  - addr_valid <= 1.
- FTW handshake:
  - Transfer occurs when ftw_valid && ftw_ready. It loads ftw_pending, sets pend_flag, and ftw_ready = !pend_flag.
  - On the next tick with pend_flag set, ftw_active <= ftw_pending and pend_flag clears. That tick's addition still uses the old ftw_active.
  - Transfer in the same cycle as a tick: the new word is not applied on that tick. It is applied on the following tick.
  - Handshake operates regardless of enable.
- div_rate may change at any time. If div_cnt > div_rate, div_cnt counts up to all-ones, rolls over to 0, and continues.
- Reset dominates all simultaneous events.

## Timing
- Reset values: phase 0, ftw_active 0, ftw_pending 0, pend_flag 0, div_cnt 0, address 0, addr_valid 0, wrap 0, ftw_ready 1.
- Latency: a tick in cycle T produces address/addr_valid/wrap valid in cycle T+1, for one cycle only.
- div_rate=0 with enable held high: addr_valid stays high every cycle.
- FTW: transfer at edge E means ftw_ready is low from E. If the first tick after E is in cycle T, ftw_ready is high again in T+1. The new step is first visible in the address produced by the tick after T.
- Reset asserted mid-operation: at the next edge all registers take their reset values and any pending FTW is discarded.

## Configuration
- NCO_DITHER_EN defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) advances once per tick.
  - Its low PHASE_WIDTH-LUT_DEPTH bits are added to phase_next for address generation only; the accumulator itself is never dithered.
  - Reduces spurs; address may differ by +1 from the undithered value.
- NCO_DITHER_EN undefined: no LFSR is built and address is pure truncation.

## Structure
- Shared package: default PHASE_WIDTH/LUT_DEPTH/DIV_WIDTH constants, LFSR polynomial and seed, and a phase_t typedef.
- One sub-module, nco_dither_lfsr, instantiated only under NCO_DITHER_EN. The rest stays flat.

## Test plan
Defaults are used unless stated; dither is off.
- Reset: hold reset high for 3 cycles with ftw_valid high. Expected: all outputs 0, ftw_ready 1, no transfer retained afterwards.
- Free run: ftw 0x010000, div_rate 0, enable 1. Expected: address 1,2,…,255,0 on consecutive cycles; wrap high only with address 0 (256th update).
- Divider: div_rate 3. Expected: addr_valid pulses exactly every 4th cycle; setting enable low for 5 cycles freezes address and div_cnt with addr_valid 0.
- Handshake: running at ftw 0x010000 with div_rate 3, offer 0x020000. Expected: ftw_ready low until the cycle after the next tick; address steps by 1 once more, then by 2; a second offer while ftw_ready is low is not accepted.
- Offset: phase_offset 64, ftw 0x010000. Expected: first address is 65; after the update with phase top bits 192, address is 0.
- Dither build: ftw 0x008000. Expected: each address is within +1 of the undithered model; the LFSR sequence matches the reference polynomial from seed ACE1.
